// File: rtl/ext_pipe.sv
// Immediate extender with a 2-entry valid/ready output FIFO.
// Optional macro EXT_BRANCH_EN: mode 11 becomes branch-offset extension; otherwise mode 11 is flagged illegal.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       ExtOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ExtOut,
    output logic             IllegalOp
);

    localparam int PAD_W = OUT_W - IN_W;

    localparam logic [1:0] OP_ZERO  = 2'b00;
    localparam logic [1:0] OP_SIGN  = 2'b01;
    localparam logic [1:0] OP_UPPER = 2'b10;

    logic [OUT_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] ext_val;
    logic             illegal_hit;
    logic             illegal_q;

    // Flow control comes only from the registered occupancy, never from out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign sext_val  = {{PAD_W{imm[IN_W-1]}}, imm};

    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        ext_val     = '0;
        illegal_hit = 1'b0;
        case (ExtOp)
            OP_ZERO:  ext_val = {{PAD_W{1'b0}}, imm};
            OP_SIGN:  ext_val = sext_val;
            OP_UPPER: ext_val = {imm, {PAD_W{1'b0}}};
            default: begin
`ifdef EXT_BRANCH_EN
                ext_val = {sext_val[OUT_W-3:0], 2'b00};
`else
                ext_val     = {OUT_W{imm[IN_W-1]}};
                illegal_hit = 1'b1;
`endif
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            illegal_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push && illegal_hit) illegal_q <= 1'b1;
        end
    end

    // NOTE: storage is two words, so it is reset too; no stale data survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= ext_val;
        end
    end

    assign ExtOut    = out_valid ? mem[rd_ptr] : '0;
    assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: a 16->32 instance and an 8->20 instance.
// Expected results come from an arithmetic reference model pushed at accept time.
module tb_ext_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16 -> 32 instance
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_illegal;
    logic [15:0] a_imm = '0;
    logic [1:0]  a_op = '0;
    logic [31:0] a_ext;

    // 8 -> 20 instance
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_illegal;
    logic [7:0]  b_imm = '0;
    logic [1:0]  b_op = '0;
    logic [19:0] b_ext;

    ext_pipe #(.IN_W(16), .OUT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .imm(a_imm), .ExtOp(a_op), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .ExtOut(a_ext), .IllegalOp(a_illegal)
    );

    ext_pipe #(.IN_W(8), .OUT_W(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .imm(b_imm), .ExtOp(b_op), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .ExtOut(b_ext), .IllegalOp(b_illegal)
    );

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    int n_checks = 0;
    int n_pass   = 0;
    bit a_acc;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    endtask

    // Reference: two's-complement arithmetic in 64 bits, then masked to the output width.
    function automatic logic [63:0] ref_ext(input int in_w, input int out_w,
                                            input logic [63:0] raw, input logic [1:0] op);
        logic [63:0] mask = (64'd1 << out_w) - 64'd1;
        bit          neg  = raw[in_w-1];
        logic [63:0] sval = neg ? raw - (64'd1 << in_w) : raw;
        logic [63:0] r;
        case (op)
            2'b00:   r = raw;
            2'b01:   r = sval;
            2'b10:   r = raw << (out_w - in_w);
`ifdef EXT_BRANCH_EN
            default: r = sval * 64'd4;
`else
            default: r = neg ? ~64'd0 : 64'd0;
`endif
        endcase
        return r & mask;
    endfunction

    // One clock: observe handshakes at the negedge, then advance to just after the posedge.
    task automatic tick();
        @(negedge clk);
        a_acc = a_in_valid && a_in_ready;
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) check("a_unexpected_out", {32'd0, a_ext}, 64'hDEAD);
            else check("a_ext_order", {32'd0, a_ext}, qa.pop_front());
        end
        if (a_acc) qa.push_back(ref_ext(16, 32, {48'd0, a_imm}, a_op));
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) check("b_unexpected_out", {44'd0, b_ext}, 64'hDEAD);
            else check("b_ext_order", {44'd0, b_ext}, qb.pop_front());
        end
        if (b_in_valid && b_in_ready) qb.push_back(ref_ext(8, 20, {56'd0, b_imm}, b_op));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (4) tick();
        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_ext", a_ext, 0);
        check("rst_illegal", a_illegal, 0);
        check("rst_b_ready", b_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back zero/sign/upper with 1-cycle latency
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_imm       = 16'h8001;
        check("lat_before_accept", a_out_valid, 0);
        a_op = 2'b00; tick();
        check("lat_valid", a_out_valid, 1);
        check("zero_ext", a_ext, 32'h0000_8001);
        a_op = 2'b01; tick();
        check("sign_ext", a_ext, 32'hFFFF_8001);
        a_op = 2'b10; tick();
        check("upper_ext", a_ext, 32'h8001_0000);
        drain();

        // Mode 11
        a_in_valid = 1'b1;
        a_op       = 2'b11;
`ifdef EXT_BRANCH_EN
        a_imm = 16'hFFFF;
        tick();
        a_in_valid = 1'b0;
        check("branch_ext", a_ext, 32'hFFFF_FFFC);
        repeat (3) tick();
        check("branch_no_illegal", a_illegal, 0);
`else
        a_imm = 16'h7FFF;
        check("illegal_pre", a_illegal, 0);
        tick();
        a_in_valid = 1'b0;
        check("illegal_ext", a_ext, 32'h0000_0000);
        check("illegal_set", a_illegal, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("illegal_sticky", a_illegal, 1);
        end
`endif
        drain();

        // Backpressure: fill to two, third offer stalls
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_op        = 2'b00;
        a_imm = 16'd1; tick();
        a_imm = 16'd2; tick();
        check("full_in_ready", a_in_ready, 0);
        a_imm = 16'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ext", a_ext, 32'd1);
            check("stall_valid", a_out_valid, 1);
        end
        a_out_ready = 1'b1;
        tick();
        check("full_pop_ready", a_in_ready, 1);
        check("no_push_when_full", a_acc, 0);
        a_acc = 1'b0;
        for (int i = 0; i < 6 && !a_acc; i++) tick();
        check("third_accepted", a_acc, 1);
        drain();

        // Random traffic on both instances
        for (int i = 0; i < 300; i++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_out_ready = 1'($urandom_range(0, 1));
            a_imm       = 16'($urandom);
            a_op        = 2'($urandom_range(0, 3));
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_imm       = 8'($urandom);
            b_op        = 2'($urandom_range(0, 2));
            tick();
        end
        drain();
`ifdef EXT_BRANCH_EN
        check("rand_no_illegal", a_illegal, 0);
`endif

        // Narrow instance
        b_in_valid = 1'b1;
        b_imm      = 8'h80;
        b_op = 2'b01; tick();
        check("narrow_sign", b_ext, 20'hFFF80);
        b_op = 2'b10; tick();
        check("narrow_upper", b_ext, 20'h80000);
        drain();

        // Asynchronous reset with two entries buffered
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_op        = 2'b11;
        a_imm = 16'h8005; tick();
        a_op  = 2'b00;
        a_imm = 16'h0006; tick();
        check("pre_rst_full", a_in_ready, 0);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_ready", a_in_ready, 1);
        check("mid_rst_ext", a_ext, 0);
        check("mid_rst_illegal", a_illegal, 0);
        qa.delete();
        qb.delete();
        a_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("in_rst_no_accept", a_out_valid, 0);
        a_in_valid = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_stale", a_out_valid, 0);
        end
        a_in_valid = 1'b1;
        a_imm      = 16'h0009;
        tick();
        check("resume_ext", a_ext, 32'h0000_0009);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width (>= 2).
REQ-002 SHALL have parameter OUT_W, default 32, extended output width (> IN_W).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all state is clocked on the rising edge of clk.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  producer offers imm/ExtOp.
REQ-007 SHALL have port in_ready  output  1  block accepts an offer this cycle.
REQ-008 SHALL have port imm  input  IN_W  raw immediate.
REQ-009 SHALL have port ExtOp  input  2  mode: 00 zero, 01 sign, 10 upper, 11 branch.
REQ-010 SHALL have port out_valid  output  1  ExtOut holds a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port ExtOut  output  OUT_W  extended result.
REQ-013 SHALL have port IllegalOp  output  1  sticky flag, unsupported mode accepted.

Function
REQ-014 SHALL accept a transfer when in_valid and in_ready are both high at a clock edge, and deliver one when out_valid and out_ready are both high.
REQ-015 SHALL compute the result at accept time: 00 -> zeros(OUT_W-IN_W) followed by imm; 01 -> imm[IN_W-1] replicated (OUT_W-IN_W) times followed by imm; 10 -> imm followed by zeros(OUT_W-IN_W).
REQ-016 SHALL, for mode 11 with EXT_BRANCH_EN defined, produce the sign-extended value shifted left by 2, dropping the top 2 bits and filling the bottom 2 with zero.
REQ-017 SHALL store results in a 2-entry in-order FIFO (count 0..2); ExtOut SHALL be the head entry.
REQ-018 SHALL give out_valid = (count != 0), registered; latency from accept to out_valid is exactly 1 cycle.
REQ-019 SHALL give in_ready = (count != 2), registered-state based; it SHALL NOT depend combinationally on out_ready.
REQ-020 SHALL sustain one transfer per cycle when count == 1 with simultaneous push and pop (count unchanged, order preserved).
REQ-021 SHALL, when full (count == 2), ignore in_valid; a pop in that cycle SHALL drop count to 1 and raise in_ready the next cycle.
REQ-022 SHALL, when empty, ignore out_ready; a pop never underflows.
REQ-023 SHALL hold ExtOut and out_valid stable while out_valid is high and out_ready is low.
REQ-024 SHALL wrap read and write pointers modulo 2.

Reset
REQ-025 SHALL, on rst_n low, immediately clear count, pointers and IllegalOp: out_valid=0, in_ready=1, ExtOut=0, IllegalOp=0.
REQ-026 SHALL discard all buffered results on reset mid-operation; no transfer is accepted or delivered while rst_n is low.
REQ-027 SHALL resume normal operation from the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL use macro EXT_BRANCH_EN: defined -> mode 11 is the branch mode of REQ-016, IllegalOp never sets.
REQ-029 SHALL, without EXT_BRANCH_EN, treat mode 11 as unsupported: the accepted result is all bits equal to imm[IN_W-1], and IllegalOp sets the cycle after acceptance and stays high until reset.

Verification
REQ-030 SHALL cover: IN_W=16, OUT_W=32, imm=16'h8001, ops 00/01/10 back-to-back, out_ready=1 -> ExtOut 32'h00008001, 32'hFFFF8001, 32'h80010000 on consecutive cycles, each one cycle after accept.
REQ-031 SHALL cover: EXT_BRANCH_EN defined, imm=16'hFFFF, op 11 -> ExtOut 32'hFFFFFFFC, IllegalOp stays 0.
REQ-032 SHALL cover: EXT_BRANCH_EN undefined, imm=16'h7FFF, op 11 -> ExtOut 32'h00000000, IllegalOp=1 the cycle after accept and held through 10 further cycles.
REQ-033 SHALL cover: out_ready=0, three offers imm=1,2,3 op 00 -> first two accepted, in_ready=0 after second, ExtOut stable at 1; then out_ready=1 -> 1,2,3 delivered in order.
REQ-034 SHALL cover: count=2, rst_n pulsed low mid-cycle -> out_valid=0, in_ready=1, ExtOut=0 immediately; no stale result appears after release.
REQ-035 SHALL cover: IN_W=8, OUT_W=20, imm=8'h80, op 01 -> ExtOut 20'hFFF80; op 10 -> 20'h80000.
